seq_detector_param: RTL

//  Parametrised serial bit-pattern detector; generalises the fixed single-pattern detector.

---
 rtl/seq_detector_param.sv | 99 +++++++++
 1 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised serial bit-pattern detector.
// Shifts valid-qualified serial bits into a history register and flags a
// registered one-cycle pulse when the last SEQ_LEN valid bits equal the
// (runtime-reloadable) pattern. Counts matches in a saturating counter.
//
// Input handshake: in_valid qualifies in for the current cycle; there is no
// ready/backpressure, every valid bit is consumed on the edge it is presented.
// pat_load takes priority over in_valid; a bit presented together with
// pat_load is dropped.
module seq_detector_param #(
   parameter int                 SEQ_LEN     = 4,
   parameter logic [SEQ_LEN-1:0] DEF_PATTERN = 4'b1011,
   parameter bit                 OVERLAP     = 1'b1,
   parameter int                 CNT_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in,
   input  logic               pat_load,
   input  logic [SEQ_LEN-1:0] pat_in,
   input  logic               clear_cnt,
   output logic               detect,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cnt_sat
);

   localparam int               FW      = $clog2(SEQ_LEN + 1);
   localparam logic [FW-1:0]    FULL    = FW'(SEQ_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [SEQ_LEN-1:0] pattern;
   logic [SEQ_LEN-1:0] hist;
   logic [FW-1:0]      fill;

   logic [SEQ_LEN-1:0] nh;
   logic [FW-1:0]      nf;
   logic               match;
   logic [SEQ_LEN-1:0] hist_nxt;
   logic [SEQ_LEN-1:0] pattern_nxt;
   logic [FW-1:0]      fill_nxt;
   logic               detect_nxt;
   logic [CNT_W-1:0]   cnt_nxt;

   // Next-state logic: pattern reload beats a valid bit; fill gates matching
   // so stale zero history can never match an all-zero pattern.
   always_comb begin
      nh          = {hist[SEQ_LEN-2:0], in};
      nf          = (fill == FULL) ? FULL : fill + FW'(1);
      match       = 1'b0;
      hist_nxt    = hist;
      fill_nxt    = fill;
      pattern_nxt = pattern;
      detect_nxt  = 1'b0;

      if (pat_load) begin
         pattern_nxt = pat_in;
         hist_nxt    = '0;
         fill_nxt    = '0;
      end else if (in_valid) begin
         match      = (nf == FULL) && (nh == pattern);
         hist_nxt   = nh;
         detect_nxt = match;
         if (match && !OVERLAP) begin
            fill_nxt = '0;
         end else begin
            fill_nxt = nf;
         end
      end

      // A clear coinciding with a match keeps that match as the first count.
      cnt_nxt = match_cnt;
      if (clear_cnt) begin
         cnt_nxt = match ? CNT_W'(1) : '0;
      end else if (match && (match_cnt != CNT_MAX)) begin
         cnt_nxt = match_cnt + CNT_W'(1);
      end
   end

   // State and output registers, asynchronously reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pattern   <= DEF_PATTERN;
         hist      <= '0;
         fill      <= '0;
         detect    <= 1'b0;
         match_cnt <= '0;
         cnt_sat   <= 1'b0;
      end else begin
         pattern   <= pattern_nxt;
         hist      <= hist_nxt;
         fill      <= fill_nxt;
         detect    <= detect_nxt;
         match_cnt <= cnt_nxt;
         cnt_sat   <= (cnt_nxt == CNT_MAX);
      end
   end

endmodule
